// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and default width for the serial adder/subtractor.
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: 1-bit combinational full adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, LSB first, one full adder reused over WIDTH cycles.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, acc;
    logic [CW-1:0] cnt;
    logic c, cm, s, co, last;
    fa_cell u_fa (.a(a_r[0]), .b(b_r[0]), .cin(c), .s(s), .co(co));
    assign last = cnt == CW'(WIDTH);
    always_comb begin
        state_nx  = (state == IDLE && in_valid)  ? CALC :
                    (state == CALC && last)      ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end
    // cm remembers the carry into the bit just computed, so after the MSB it is the carry into the MSB
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            cm    <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_r <= a;
                b_r <= b ^ {WIDTH{sub}};
                c   <= sub;
                cnt <= '0;
            end
            if (state == CALC) begin
                if (last) begin
                    sum  <= acc;
                    cout <= c;
                    ovf  <= c ^ cm;
                end else begin
                    a_r <= a_r >> 1;
                    b_r <= b_r >> 1;
                    acc <= {s, acc[WIDTH-1:1]};
                    cm  <= c;
                    c   <= co;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
